mem_arbiter: RTL

//  Shares the single-port rw_ram (wr_en/addr/w_data/r_data) between two requesters:

---
 rtl/mem_pkg.sv | 17 +
 rtl/rd_tag_pipe.sv | 36 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for multi-master memory blocks: owner-state encoding and port ids.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } owner_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic owner_state_e own_state(input logic port);
        return (port == PORT1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, port} tags that tracks reads in flight
// so returning RAM data can be steered to the port that issued the read.
module rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_port,
    output logic o_valid,
    output logic o_port
);

    logic [RD_LAT-1:0] r_valid;
    logic [RD_LAT-1:0] r_port;
    logic [RD_LAT:0]   w_valid_chain;
    logic [RD_LAT:0]   w_port_chain;

    // Stage 0 of each chain is the incoming tag, so one shift covers any depth >= 1.
    assign w_valid_chain = {r_valid, i_valid};
    assign w_port_chain  = {r_port, i_port};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_port  <= '0;
        end else begin
            r_valid <= w_valid_chain[RD_LAT-1:0];
            r_port  <= w_port_chain[RD_LAT-1:0];
        end
    end

    assign o_valid = r_valid[RD_LAT-1];
    assign o_port  = r_port[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data RAM between two masters: round-robin with a bounded
// burst per owner, single access per cycle, read data returned to the issuing port.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    // Handshake: a master holds req with stable we/addr/wdata until it sees gnt;
    // gnt high means the RAM access is issued in that same cycle.
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic [1:0]        o_dbg_state
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    owner_state_e      r_state;
    owner_state_e      w_next_state;
    logic              r_last_owner;
    logic [CNT_W-1:0]  r_burst_cnt;

    logic              w_owner;
    logic              w_req_own;
    logic              w_req_oth;
    logic              w_under_limit;
    logic              w_grant_valid;
    logic              w_grant_port;
    logic              w_issue;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_rd_valid;
    logic              w_rd_port;

    assign w_owner       = (r_state == ST_OWN1);
    assign w_req_own     = w_owner ? m1_req : m0_req;
    assign w_req_oth     = w_owner ? m0_req : m1_req;
    assign w_under_limit = (r_burst_cnt < BURST_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_port  = PORT0;
        case (r_state)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = ~r_last_owner;
                end else if (m0_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = PORT0;
                end else if (m1_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = PORT1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                // The burst limit only bites while the other port is waiting.
                if (w_req_own && (!w_req_oth || w_under_limit)) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = w_owner;
                end else if (w_req_oth) begin
                    w_grant_valid = 1'b1;
                    w_grant_port  = ~w_owner;
                end
            end
            default: begin
                w_grant_valid = 1'b0;
                w_grant_port  = PORT0;
            end
        endcase
        w_next_state = w_grant_valid ? own_state(w_grant_port) : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_owner <= PORT1;
            r_burst_cnt  <= '0;
        end else if (!w_grant_valid) begin
            r_burst_cnt  <= '0;
        end else begin
            r_last_owner <= w_grant_port;
            if (r_state == own_state(w_grant_port)) begin
                if (r_burst_cnt != BURST_LAST) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end else begin
                r_burst_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_issue     = w_grant_valid & ~reset;
        w_sel_we    = (w_grant_port == PORT1) ? m1_we    : m0_we;
        w_sel_addr  = (w_grant_port == PORT1) ? m1_addr  : m0_addr;
        w_sel_wdata = (w_grant_port == PORT1) ? m1_wdata : m0_wdata;
        m0_gnt      = w_issue & (w_grant_port == PORT0);
        m1_gnt      = w_issue & (w_grant_port == PORT1);
        mem_wr_en   = w_issue & w_sel_we;
        mem_addr    = w_issue ? w_sel_addr  : '0;
        mem_w_data  = w_issue ? w_sel_wdata : '0;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_issue & ~w_sel_we),
        .i_port  (w_grant_port),
        .o_valid (w_rd_valid),
        .o_port  (w_rd_port)
    );

    // Reads still in flight when reset hits are dropped, including the reset cycle itself.
    assign m0_rvalid   = w_rd_valid & ~reset & (w_rd_port == PORT0);
    assign m1_rvalid   = w_rd_valid & ~reset & (w_rd_port == PORT1);
    assign m0_rdata    = m0_rvalid ? mem_r_data : '0;
    assign m1_rdata    = m1_rvalid ? mem_r_data : '0;
    assign o_dbg_state = r_state;

endmodule
